imem_port: RTL and testbench

Parametrised instruction memory with a valid/ready request/response interface, configurable wait states, and error reporting. It replaces the fixed single-cycle instruction ROM in the fetch path. The fetch stage can stall it in either direction, and slow memories can be modelled with programmable latency. Contents are preloaded through a simulator-visible backdoor task. There is no run-time write port.

---
 rtl/imem_port.sv | 152 +++++++++++++++
 tb/tb_imem_port.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port.sv
// imem_port: parametrised instruction memory with a valid/ready fetch port,
// programmable wait states and access-fault reporting. Contents are preloaded
// through the writeByte task; there is no run-time write port.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_valid_i  fetch request present
//   req_addr_i   byte address of the request
//   req_ready_o  request accepted when high together with req_valid_i
//   rsp_valid_o  response present
//   rsp_ready_i  consumer takes the response
//   rsp_data_o   fetched word (0 on error)
//   rsp_err_o    access fault: out of range or misaligned
//   busy_o       high whenever the FSM is not idle
module imem_port #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       MEM_BYTES   = 4096,
  parameter logic [ADDR_W-1:0] MEM_BASE    = '0,
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter bit                BIG_ENDIAN  = 1'b1,
  parameter bit                ALIGN_ERR   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              busy_o
);

  localparam int unsigned       BYTES     = DATA_W / 8;
  localparam int unsigned       MEM_AW    = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] LSB_MASK  = ADDR_W'(BYTES - 1);
  localparam logic [MEM_AW-1:0] WORD_MASK = ~MEM_AW'(BYTES - 1);
  // One extra bit so a memory spanning the whole address space still compares.
  localparam logic [ADDR_W:0]   MEM_SIZE  = (ADDR_W + 1)'(MEM_BYTES);
  localparam logic [3:0]        CNT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  logic [7:0]        mem [MEM_BYTES];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic              accept;
  logic              load_rsp;
  logic [ADDR_W-1:0] lk_addr;
  logic [ADDR_W-1:0] offset;
  logic [MEM_AW-1:0] word_base;
  logic              out_of_range;
  logic              misaligned;
  logic              lk_err;
  logic [DATA_W-1:0] lk_data;

  // Backdoor preload; addresses outside the memory window are dropped.
  task automatic writeByte(input logic [ADDR_W-1:0] addr, input logic [7:0] val);
    logic [ADDR_W-1:0] off;
    off = addr - MEM_BASE;
    if ((addr >= MEM_BASE) && ({1'b0, off} < MEM_SIZE))
      mem[off[MEM_AW-1:0]] = val;
  endtask

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept)   addr_q <= req_addr_i;
      if (load_rsp) begin
        rsp_data_q <= lk_data;
        rsp_err_q  <= lk_err;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: if (req_valid_i) accept = 1'b1;
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          if (req_valid_i) accept  = 1'b1;
          else             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      cnt_d   = CNT_LOAD;
    end
  end

  // Response registers load only on entry into RESP (from WAIT, or directly
  // on accept with no wait states), which keeps them frozen under backpressure.
  assign load_rsp = (state_d == S_RESP) && (accept || (state_q == S_WAIT));

  // Lookup uses the live request address when loading straight from an
  // accept, otherwise the latched one; both equal the latched address.
  always_comb begin
    lk_addr      = (state_q == S_WAIT) ? addr_q : req_addr_i;
    offset       = lk_addr - MEM_BASE;
    out_of_range = (lk_addr < MEM_BASE) || ({1'b0, offset} >= MEM_SIZE);
    misaligned   = ALIGN_ERR && ((lk_addr & LSB_MASK) != '0);
    lk_err       = out_of_range || misaligned;
    word_base    = offset[MEM_AW-1:0] & WORD_MASK;
    lk_data      = '0;
    for (int unsigned k = 0; k < BYTES; k++) begin
      if (BIG_ENDIAN) lk_data[(BYTES-1-k)*8 +: 8] = mem[word_base + MEM_AW'(k)];
      else            lk_data[k*8 +: 8]           = mem[word_base + MEM_AW'(k)];
    end
    if (lk_err) lk_data = '0;
  end

  // Output logic
  always_comb begin
    req_ready_o = 1'b0;
    unique case (state_q)
      S_IDLE:  req_ready_o = rst_ni;
      S_RESP:  req_ready_o = rst_ni && rsp_ready_i;
      default: req_ready_o = 1'b0;
    endcase
    rsp_valid_o = (state_q == S_RESP);
    busy_o      = (state_q != S_IDLE);
    rsp_data_o  = rsp_data_q;
    rsp_err_o   = rsp_err_q;
  end

endmodule

// File: tb/tb_imem_port.sv
module tb_imem_port;

  logic        clk;
  logic        rst_n;
  logic        rsp_ready;
  logic [31:0] addr;
  logic [5:0]  vld, rdy, rv, er, bz;
  logic [31:0] d0, d1, d2, d3, d4;
  logic [63:0] d5;
  int          sel;
  logic [63:0] mon_data;
  logic        mon_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;
  exp_t q[$];
  exp_t e;

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [63:0] data;
    logic        err;
  } vec_t;
  vec_t vecs [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u0: defaults (base 0, no wait, big-endian, alignment checked)
  imem_port u0 (.clk_i(clk), .rst_ni(rst_n), .req_valid_i(vld[0]), .req_addr_i(addr),
    .req_ready_o(rdy[0]), .rsp_valid_o(rv[0]), .rsp_ready_i(rsp_ready),
    .rsp_data_o(d0), .rsp_err_o(er[0]), .busy_o(bz[0]));
  imem_port #(.MEM_BASE(32'h1000), .ALIGN_ERR(1'b1)) u1 (.clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(vld[1]), .req_addr_i(addr), .req_ready_o(rdy[1]), .rsp_valid_o(rv[1]),
    .rsp_ready_i(rsp_ready), .rsp_data_o(d1), .rsp_err_o(er[1]), .busy_o(bz[1]));
  imem_port #(.MEM_BASE(32'h1000), .ALIGN_ERR(1'b0)) u2 (.clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(vld[2]), .req_addr_i(addr), .req_ready_o(rdy[2]), .rsp_valid_o(rv[2]),
    .rsp_ready_i(rsp_ready), .rsp_data_o(d2), .rsp_err_o(er[2]), .busy_o(bz[2]));
  imem_port #(.WAIT_CYCLES(2)) u3 (.clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(vld[3]), .req_addr_i(addr), .req_ready_o(rdy[3]), .rsp_valid_o(rv[3]),
    .rsp_ready_i(rsp_ready), .rsp_data_o(d3), .rsp_err_o(er[3]), .busy_o(bz[3]));
  imem_port #(.WAIT_CYCLES(3)) u4 (.clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(vld[4]), .req_addr_i(addr), .req_ready_o(rdy[4]), .rsp_valid_o(rv[4]),
    .rsp_ready_i(rsp_ready), .rsp_data_o(d4), .rsp_err_o(er[4]), .busy_o(bz[4]));
  imem_port #(.DATA_W(64), .BIG_ENDIAN(1'b0)) u5 (.clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(vld[5]), .req_addr_i(addr), .req_ready_o(rdy[5]), .rsp_valid_o(rv[5]),
    .rsp_ready_i(rsp_ready), .rsp_data_o(d5), .rsp_err_o(er[5]), .busy_o(bz[5]));

  always_comb begin
    mon_data = '0;
    case (sel)
      0: mon_data = {32'h0, d0};
      1: mon_data = {32'h0, d1};
      2: mon_data = {32'h0, d2};
      3: mon_data = {32'h0, d3};
      4: mon_data = {32'h0, d4};
      default: mon_data = d5;
    endcase
    mon_err = er[sel];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input int d, input logic [31:0] a, input logic [7:0] b);
    case (d)
      0: u0.writeByte(a, b);
      1: u1.writeByte(a, b);
      2: u2.writeByte(a, b);
      3: u3.writeByte(a, b);
      4: u4.writeByte(a, b);
      default: u5.writeByte(a, b);
    endcase
  endtask

  // Scoreboard: each consumed response pops the oldest expectation; only the
  // selected instance may ever present a response.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("stray_valid", 64'(rv & ~(6'd1 << sel)), 64'h0);
      if (rv[sel] && rsp_ready) begin
        if (q.size() == 0) chk("unexpected_rsp", 64'h1, 64'h0);
        else begin
          e = q.pop_front();
          chk("rsp_data", mon_data, e.data);
          chk("rsp_err", 64'(mon_err), 64'(e.err));
        end
      end
    end
  end

  task automatic issue(input int d, input logic [31:0] a, input logic [63:0] ed, input logic ee);
    bit got;
    @(posedge clk); #1;
    q.push_back('{ed, ee});
    sel    = d;
    addr   = a;
    vld[d] = 1'b1;
    got    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy[d]) begin got = 1'b1; break; end
    end
    if (!got) chk("accept_timeout", 64'h0, 64'h1);
    @(posedge clk); #1;
    vld[d] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    chk("drain_timeout", 64'(q.size()), 64'h0);
  endtask

  initial begin
    logic [7:0] pat0 [8];
    pat0 = '{8'h13, 8'h57, 8'h9B, 8'hDF, 8'h02, 8'h46, 8'h8A, 8'hCE};
    rst_n = 1'b0; rsp_ready = 1'b1; addr = '0; vld = '0; sel = 0;

    for (int i = 0; i < 8; i++) begin
      preload(0, 32'(i), pat0[i]);
      preload(5, 32'(i), 8'(i + 1));
      preload(5, 32'hFF8 + 32'(i), 8'hF0 + 8'(i));
    end
    for (int i = 0; i < 4; i++) begin
      preload(0, 32'hFFC + 32'(i), 8'hDE - 8'(i * 'h11) + ((i == 1) ? 8'h00 : 8'h00));
      preload(1, 32'h1000 + 32'(i), 8'h11 * 8'(i + 1));
      preload(2, 32'h1000 + 32'(i), 8'h11 * 8'(i + 1));
      preload(1, 32'h1FFC + 32'(i), 8'hA1 + 8'(i * 'h11));
      preload(2, 32'h1FFC + 32'(i), 8'hA1 + 8'(i * 'h11));
    end
    // bytes 0xFFC..0xFFF of u0 = DE CD BC AB
    preload(3, 32'h0, 8'hCA); preload(3, 32'h1, 8'hFE);
    preload(3, 32'h2, 8'hBA); preload(3, 32'h3, 8'hBE);

    vecs[0]  = '{0, 32'h0000_0000, 64'h13579BDF, 1'b0};
    vecs[1]  = '{0, 32'h0000_0004, 64'h02468ACE, 1'b0};
    vecs[2]  = '{0, 32'h0000_0FFC, 64'hDECDBCAB, 1'b0};
    vecs[3]  = '{0, 32'h0000_1000, 64'h0, 1'b1};
    vecs[4]  = '{0, 32'h0000_0006, 64'h0, 1'b1};
    vecs[5]  = '{1, 32'h0000_0FFC, 64'h0, 1'b1};
    vecs[6]  = '{1, 32'h0000_2000, 64'h0, 1'b1};
    vecs[7]  = '{1, 32'h0000_1FFC, 64'hA1B2C3D4, 1'b0};
    vecs[8]  = '{1, 32'h0000_1002, 64'h0, 1'b1};
    vecs[9]  = '{2, 32'h0000_1002, 64'h11223344, 1'b0};
    vecs[10] = '{2, 32'h0000_1FFF, 64'hA1B2C3D4, 1'b0};
    vecs[11] = '{2, 32'hFFFF_FFFF, 64'h0, 1'b1};
    vecs[12] = '{5, 32'h0000_0000, 64'h0807060504030201, 1'b0};
    vecs[13] = '{5, 32'h0000_0FF8, 64'hF7F6F5F4F3F2F1F0, 1'b0};
    vecs[14] = '{5, 32'h0000_0004, 64'h0, 1'b1};
    vecs[15] = '{3, 32'h0000_0000, 64'hCAFEBABE, 1'b0};

    // Reset state
    #1;
    chk("rst_valid", 64'(rv), 64'h0);
    chk("rst_busy", 64'(bz), 64'h0);
    chk("rst_err", 64'(er), 64'h0);
    chk("rst_data", {32'h0, d0}, 64'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("ready_after_rst", 64'(rdy), 64'h3F);

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].d, vecs[i].a, vecs[i].data, vecs[i].err);
      drain();
    end

    // Back-to-back, no wait states: one response per cycle
    @(posedge clk); #1;
    sel = 0; rsp_ready = 1'b1;
    q.push_back('{64'h13579BDF, 1'b0});
    q.push_back('{64'h02468ACE, 1'b0});
    vld[0] = 1'b1; addr = 32'h0;
    @(negedge clk);
    chk("b2b_ready0", 64'(rdy[0]), 64'h1);
    @(posedge clk); #1;
    addr = 32'h4;
    @(negedge clk);
    chk("b2b_valid1", 64'(rv[0]), 64'h1);
    chk("b2b_data1", {32'h0, d0}, 64'h13579BDF);
    chk("b2b_ready1", 64'(rdy[0]), 64'h1);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    @(negedge clk);
    chk("b2b_valid2", 64'(rv[0]), 64'h1);
    chk("b2b_data2", {32'h0, d0}, 64'h02468ACE);
    chk("b2b_err2", 64'(er[0]), 64'h0);
    drain();

    // Wait states and backpressure (WAIT_CYCLES=2): request presented after edge N
    @(posedge clk); #1;
    sel = 3; rsp_ready = 1'b0;
    q.push_back('{64'hCAFEBABE, 1'b0});
    vld[3] = 1'b1; addr = 32'h0;
    @(posedge clk); #1;                 // N+1: accepted
    vld[3] = 1'b0;
    @(negedge clk);
    chk("ws_valid_n1", 64'(rv[3]), 64'h0);
    chk("ws_ready_n1", 64'(rdy[3]), 64'h0);
    chk("ws_busy_n1", 64'(bz[3]), 64'h1);
    @(negedge clk);                     // after N+2
    chk("ws_valid_n2", 64'(rv[3]), 64'h0);
    for (int i = 0; i < 3; i++) begin   // after N+3, held for three cycles
      @(negedge clk);
      chk("bp_valid", 64'(rv[3]), 64'h1);
      chk("bp_data", {32'h0, d3}, 64'hCAFEBABE);
      chk("bp_ready", 64'(rdy[3]), 64'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();

    // Out-of-window backdoor writes leave the memory intact
    u1.writeByte(32'h2000, 8'hAA);
    u1.writeByte(32'h0FFF, 8'hAA);
    issue(1, 32'h1FFC, 64'hA1B2C3D4, 1'b0);
    drain();
    issue(1, 32'h1000, 64'h11223344, 1'b0);
    drain();

    // Reset in the middle of WAIT (WAIT_CYCLES=3): response is dropped
    @(posedge clk); #1;
    sel = 4; rsp_ready = 1'b1;
    vld[4] = 1'b1; addr = 32'h0;
    @(posedge clk); #1;
    vld[4] = 1'b0;
    @(posedge clk); #1;
    chk("mid_wait_busy", 64'(bz[4]), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(rv[4]), 64'h0);
    chk("rst_mid_busy", 64'(bz[4]), 64'h0);
    chk("rst_mid_err", 64'(er[4]), 64'h0);
    chk("rst_mid_data", {32'h0, d4}, 64'h0);
    chk("rst_mid_ready", 64'(rdy[4]), 64'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1 chk("rst_rel_ready", 64'(rdy[4]), 64'h1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_stale_rsp", 64'(rv[4]), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
